seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_pkg.sv | 26 ++
 rtl/bcd7seg_dec.sv | 26 ++
 rtl/seg_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 3-digit seven-segment scanner.
// Segment patterns are ordered {g,f,e,d,c,b,a}, active-high.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } scan_state_t;

   localparam int NUM_DIGITS = 3;

   localparam logic [6:0] SEG_0    = 7'b0111111;
   localparam logic [6:0] SEG_1    = 7'b0000110;
   localparam logic [6:0] SEG_2    = 7'b1011011;
   localparam logic [6:0] SEG_3    = 7'b1001111;
   localparam logic [6:0] SEG_4    = 7'b1100110;
   localparam logic [6:0] SEG_5    = 7'b1101101;
   localparam logic [6:0] SEG_6    = 7'b1111101;
   localparam logic [6:0] SEG_7    = 7'b0000111;
   localparam logic [6:0] SEG_8    = 7'b1111111;
   localparam logic [6:0] SEG_9    = 7'b1101111;
   localparam logic [6:0] SEG_DASH = 7'b1000000;
   localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/bcd7seg_dec.sv
// Combinational BCD to seven-segment decode; non-decimal codes show a dash.
module bcd7seg_dec
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Three-digit seven-segment scan controller: dead-time/drive sequencing per digit,
// leading-zero blanking, and a one-deep pending buffer swapped in at frame boundaries.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int CLK_DIV        = 1000,
   parameter int BLANK_TICKS    = 1,
   parameter int ON_TICKS       = 4,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [11:0] digits_in,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic        lz_blank,
   output logic [6:0]  d7sp,
   output logic [2:0]  transistor,
   output logic        frame_done
);

   localparam logic [15:0] PRESC_MAX  = 16'(CLK_DIV - 1);
   localparam logic [3:0]  BLANK_LAST = 4'(BLANK_TICKS - 1);
   localparam logic [3:0]  ON_LAST    = 4'(ON_TICKS - 1);
   localparam logic [1:0]  LAST_DIGIT = 2'(NUM_DIGITS - 1);

   scan_state_t state_reg, state_next;
   logic [1:0]  digit_reg, digit_next;
   logic [3:0]  tcnt_reg, tcnt_next;
   logic [15:0] presc_reg, presc_next;

   logic [11:0] display_reg, pending_reg;
   logic        pending_full_reg;
   logic [6:0]  seg_reg;
   logic        frame_done_reg;

   logic        tick, last_tick, frame_end, on_entry, xfer, blank_digit;
   logic [3:0]  nibble;
   logic [6:0]  dec_seg, seg_active;

   assign tick      = (state_reg != ST_OFF) && enable && (presc_reg == PRESC_MAX);
   assign last_tick = tick && (tcnt_reg == ((state_reg == ST_ON) ? ON_LAST : BLANK_LAST));
   assign frame_end = (state_reg == ST_ON) && (digit_reg == LAST_DIGIT) && last_tick;
   assign on_entry  = (state_reg == ST_BLANK) && last_tick;
   assign xfer      = load_valid && load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_OFF;
         digit_reg <= '0;
         tcnt_reg  <= '0;
         presc_reg <= '0;
      end else begin
         state_reg <= state_next;
         digit_reg <= digit_next;
         tcnt_reg  <= tcnt_next;
         presc_reg <= presc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      digit_next = digit_reg;
      tcnt_next  = tcnt_reg;
      presc_next = presc_reg;
      if (!enable) begin
         state_next = ST_OFF;
         digit_next = '0;
         tcnt_next  = '0;
         presc_next = '0;
      end else begin
         if (state_reg != ST_OFF)
            presc_next = (presc_reg == PRESC_MAX) ? '0 : presc_reg + 16'd1;
         case (state_reg)
            ST_OFF: begin
               state_next = ST_BLANK;
               digit_next = '0;
               tcnt_next  = '0;
            end
            ST_BLANK: begin
               if (last_tick) begin
                  state_next = ST_ON;
                  tcnt_next  = '0;
               end else if (tick) begin
                  tcnt_next = tcnt_reg + 4'd1;
               end
            end
            ST_ON: begin
               if (last_tick) begin
                  state_next = ST_BLANK;
                  tcnt_next  = '0;
                  digit_next = (digit_reg == LAST_DIGIT) ? 2'd0 : digit_reg + 2'd1;
               end else if (tick) begin
                  tcnt_next = tcnt_reg + 4'd1;
               end
            end
            default: state_next = ST_OFF;
         endcase
      end
   end

   always_comb begin
      nibble = display_reg[3:0];
      case (digit_reg)
         2'd1:    nibble = display_reg[7:4];
         2'd2:    nibble = display_reg[11:8];
         default: nibble = display_reg[3:0];
      endcase
   end

   // Digit 0 is never blanked so an all-zero value still shows "0".
   assign blank_digit = lz_blank &&
                        (((digit_reg == 2'd2) && (display_reg[11:8] == 4'd0)) ||
                         ((digit_reg == 2'd1) && (display_reg[11:4] == 8'd0)));

   bcd7seg_dec u_dec (
      .bcd (nibble),
      .seg (dec_seg)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         display_reg      <= '0;
         pending_reg      <= '0;
         pending_full_reg <= 1'b0;
         seg_reg          <= SEG_OFF;
         frame_done_reg   <= 1'b0;
      end else begin
         frame_done_reg <= frame_end;
         if (on_entry)
            seg_reg <= blank_digit ? SEG_OFF : dec_seg;
         // At a boundary the pending slot wins; an empty slot lets a same-cycle offer go straight through.
         if (frame_end && pending_full_reg) begin
            display_reg      <= pending_reg;
            pending_full_reg <= 1'b0;
         end else if (frame_end && xfer) begin
            display_reg <= digits_in;
         end else if (xfer) begin
            pending_reg      <= digits_in;
            pending_full_reg <= 1'b1;
         end
      end
   end

   assign load_ready = !pending_full_reg;
   assign frame_done = frame_done_reg;

   always_comb begin
      seg_active = (state_reg == ST_ON) ? seg_reg : SEG_OFF;
      d7sp       = (SEG_ACTIVE_LOW != 0) ? ~seg_active : seg_active;
   end

   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign transistor[gi] = (state_reg == ST_ON) && (digit_reg == 2'(gi));
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios then random loads,
// all checked against a frame-position model of the scanner.
module tb_seg_scan_ctrl;

   localparam int CLK_DIV   = 4;
   localparam int BT        = 1;
   localparam int OT        = 3;
   localparam int SLOT      = (BT + OT) * CLK_DIV;
   localparam int FRAME     = 3 * SLOT;
   localparam int BLANK_CYC = BT * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst, enable, load_valid, lz_blank;
   logic [11:0] digits_in;
   logic        load_ready, frame_done, load_ready_n, frame_done_n;
   logic [6:0]  d7sp, d7sp_n;
   logic [2:0]  transistor, transistor_n;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_TICKS(BT), .ON_TICKS(OT), .SEG_ACTIVE_LOW(0)) dut (
      .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load_valid(load_valid),
      .load_ready(load_ready), .lz_blank(lz_blank), .d7sp(d7sp), .transistor(transistor),
      .frame_done(frame_done)
   );

   seg_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_TICKS(BT), .ON_TICKS(OT), .SEG_ACTIVE_LOW(1)) dut_n (
      .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load_valid(load_valid),
      .load_ready(load_ready_n), .lz_blank(lz_blank), .d7sp(d7sp_n), .transistor(transistor_n),
      .frame_done(frame_done_n)
   );

   // Model: position m_t within the 48-cycle frame, counted from the first BLANK cycle.
   bit          m_run, m_pfull, m_fd;
   int          m_t;
   logic [11:0] m_disp, m_pend;
   logic [6:0]  m_seg;
   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;

   function automatic logic [6:0] pat(input logic [3:0] v);
      case (v)
         4'd0: return 7'h3F;
         4'd1: return 7'h06;
         4'd2: return 7'h5B;
         4'd3: return 7'h4F;
         4'd4: return 7'h66;
         4'd5: return 7'h6D;
         4'd6: return 7'h7D;
         4'd7: return 7'h07;
         4'd8: return 7'h7F;
         4'd9: return 7'h6F;
         default: return 7'h40;
      endcase
   endfunction

   function automatic logic [6:0] digit_pattern(input logic [11:0] disp, input int slot, input bit lz);
      if (lz && slot == 2 && disp[11:8] == 4'd0) return 7'h00;
      if (lz && slot == 1 && disp[11:4] == 8'd0) return 7'h00;
      return pat(disp[slot*4 +: 4]);
   endfunction

   task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      logic [2:0] et;
      logic [6:0] es, esn;
      if (m_run && (m_t % SLOT) >= BLANK_CYC) begin
         et = 3'b001 << (m_t / SLOT);
         es = m_seg;
      end else begin
         et = 3'b000;
         es = 7'h00;
      end
      esn = ~es;
      check("transistor", {9'd0, transistor}, {9'd0, et});
      check("d7sp", {5'd0, d7sp}, {5'd0, es});
      check("frame_done", {11'd0, frame_done}, {11'd0, m_fd});
      check("load_ready", {11'd0, load_ready}, {11'd0, !m_pfull});
      check("d7sp_active_low", {5'd0, d7sp_n}, {5'd0, esn});
      check("transistor_active_low", {9'd0, transistor_n}, {9'd0, et});
      check("frame_done_active_low", {11'd0, frame_done_n}, {11'd0, m_fd});
   endtask

   // Advance the model by the clock edge about to occur, then compare after that edge.
   task automatic step();
      bit          xfer, boundary, nrun;
      int          nt;
      logic [11:0] old_disp;
      old_disp = m_disp;
      xfer     = load_valid && !m_pfull;
      boundary = m_run && enable && (m_t == FRAME - 1);
      if (boundary) begin
         if (m_pfull) begin
            m_disp  = m_pend;
            m_pfull = 1'b0;
         end else if (xfer) begin
            m_disp = digits_in;
         end
      end else if (xfer) begin
         m_pend  = digits_in;
         m_pfull = 1'b1;
      end
      m_fd = boundary;
      if (!enable) begin
         nrun = 1'b0; nt = 0;
      end else if (!m_run) begin
         nrun = 1'b1; nt = 0;
      end else begin
         nrun = 1'b1; nt = (m_t + 1) % FRAME;
      end
      if (nrun && (nt % SLOT) == BLANK_CYC)
         m_seg = digit_pattern(old_disp, nt / SLOT, lz_blank);
      m_run = nrun;
      m_t   = nt;
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic run_until_t(input int target);
      int k;
      k = 0;
      while (!(m_run && m_t == target) && k < 200) begin
         step();
         k++;
      end
      n_assert++;
      assert (k < 200) else begin
         n_fail++;
         $error("FAIL wait_frame_pos: observed timeout after %0d cycles expected position %0d", k, target);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_transistor", {9'd0, transistor}, 12'd0);
      check("rst_d7sp", {5'd0, d7sp}, 12'd0);
      check("rst_d7sp_active_low", {5'd0, d7sp_n}, 12'h07F);
      check("rst_frame_done", {11'd0, frame_done}, 12'd0);
      check("rst_load_ready", {11'd0, load_ready}, 12'd1);
      m_run = 1'b0; m_t = 0; m_disp = '0; m_pend = '0; m_pfull = 1'b0; m_seg = '0; m_fd = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = 0;
      check_outputs();
   endtask

   initial begin
      int fd_first, fd_second;
      rst = 1'b0; enable = 1'b0; load_valid = 1'b0; lz_blank = 1'b0; digits_in = '0;
      #2;
      do_reset();
      run(3);

      // First frame from reset with digits 000
      enable = 1'b1;
      fd_first = -1; fd_second = -1;
      for (int i = 1; i <= 100; i++) begin
         step();
         if (frame_done === 1'b1) begin
            if (fd_first < 0) fd_first = i;
            else if (fd_second < 0) fd_second = i;
         end
      end
      check("first_frame_done_cycle", 12'(fd_first), 12'd49);
      check("frame_period", 12'(fd_second - fd_first), 12'(FRAME));

      // Mid-frame load of 0x123 waits for the boundary
      run_until_t(10);
      digits_in = 12'h123; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      check("pending_blocks_ready", {11'd0, load_ready}, 12'd0);
      run(110);

      // Leading-zero blanking with 0x007
      lz_blank = 1'b1;
      digits_in = 12'h007; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      run(110);

      // Non-decimal nibbles show dash
      digits_in = 12'h0AF; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      run(110);

      // Offer landing exactly on the frame boundary with pending empty
      run_until_t(FRAME - 1);
      digits_in = 12'h456; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      check("boundary_direct_ready", {11'd0, load_ready}, 12'd1);
      run(60);

      // Reset during digit 1 ON
      run_until_t(SLOT + BLANK_CYC + 3);
      do_reset();
      run(60);

      // Drop enable during digit 2 ON, then resume
      digits_in = 12'h890; load_valid = 1'b1;
      step();
      load_valid = 1'b0;
      run(60);
      run_until_t(2 * SLOT + BLANK_CYC + 2);
      enable = 1'b0;
      step();
      check("disable_transistor_off", {9'd0, transistor}, 12'd0);
      run(5);
      enable = 1'b1;
      run(60);

      // Random loads, blanking toggles and brief enable drops
      for (int i = 0; i < 3000; i++) begin
         load_valid = ($urandom_range(0, 7) == 0);
         digits_in  = 12'($urandom);
         if ($urandom_range(0, 199) == 0) lz_blank = ~lz_blank;
         enable = ($urandom_range(0, 499) != 0);
         step();
      end
      load_valid = 1'b0;
      enable = 1'b1;
      run(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
